imm_splitter: RTL

//  Inverse of the immediate extender: takes a 32-bit constant and emits the (imm16, EOp) beats that rebuild it.

---
 rtl/imm_splitter_if.sv | 22 ++
 rtl/imm_splitter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/imm_splitter_if.sv
// Handshake bundle between the constant source, the immediate splitter and the instruction builder.
// The slave modport is the splitter's view; the master modport is the driver/consumer side.
interface imm_splitter_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_imm;
  logic [1:0]  out_eop;
  logic        out_last;

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, out_imm, out_eop, out_last
  );

  modport master (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, out_imm, out_eop, out_last
  );
endinterface

// File: rtl/imm_splitter.sv
// Splits a 32-bit constant into one or two (imm16, EOp) beats that the immediate
// extender rebuilds: a single EOp form where possible, otherwise lui + ori.
module imm_splitter #(
  parameter int unsigned CNT_W       = 16,
  parameter bit          ALLOW_SHIFT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  imm_splitter_if.slave    bus,
  output logic [CNT_W-1:0] value_cnt,
  output logic [CNT_W-1:0] split_cnt
);

  localparam int unsigned IMM_W = 16;
  localparam int unsigned EOP_W = 2;

  localparam logic [EOP_W-1:0] EOP_SEXT  = 2'b00;
  localparam logic [EOP_W-1:0] EOP_ZEXT  = 2'b01;
  localparam logic [EOP_W-1:0] EOP_LUI   = 2'b10;
  localparam logic [EOP_W-1:0] EOP_SHIFT = 2'b11;

  typedef enum logic [1:0] {IDLE, SINGLE, HI, LO} state_t;

  state_t           state_q, state_d;
  logic [IMM_W-1:0] imm_q, imm_d;
  logic [EOP_W-1:0] eop_q, eop_d;
  logic             last_q, last_d;
  logic [IMM_W-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] value_cnt_q, value_cnt_d;
  logic [CNT_W-1:0] split_cnt_q, split_cnt_d;

  logic             out_valid_c;
  logic             out_fire_c;
  logic             in_ready_c;
  logic             in_fire_c;

  state_t           ld_state_c;
  logic [IMM_W-1:0] ld_imm_c;
  logic [EOP_W-1:0] ld_eop_c;
  logic             ld_last_c;

  assign out_valid_c = (state_q != IDLE);
  assign out_fire_c  = out_valid_c & bus.out_ready;
  assign in_ready_c  = (state_q == IDLE) | (out_fire_c & last_q);
  assign in_fire_c   = bus.in_valid & in_ready_c;

  // Classify the incoming constant; first matching form wins.
  always_comb begin
    logic [31:0] v;
    v          = bus.in_value;
    ld_state_c = SINGLE;
    ld_imm_c   = v[15:0];
    ld_eop_c   = EOP_SEXT;
    ld_last_c  = 1'b1;
    if ((&v[31:15]) || !(|v[31:15])) begin
      ld_eop_c = EOP_SEXT;
    end else if (!(|v[31:16])) begin
      ld_eop_c = EOP_ZEXT;
    end else if (!(|v[15:0])) begin
      ld_eop_c = EOP_LUI;
      ld_imm_c = v[31:16];
    end else if (ALLOW_SHIFT && !(|v[1:0]) && ((&v[31:17]) || !(|v[31:17]))) begin
      ld_eop_c = EOP_SHIFT;
      ld_imm_c = v[17:2];
    end else begin
      ld_state_c = HI;
      ld_eop_c   = EOP_LUI;
      ld_imm_c   = v[31:16];
      ld_last_c  = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    imm_d       = imm_q;
    eop_d       = eop_q;
    last_d      = last_q;
    lo_d        = lo_q;
    value_cnt_d = value_cnt_q;
    split_cnt_d = split_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (in_fire_c) begin
          state_d = ld_state_c;
          imm_d   = ld_imm_c;
          eop_d   = ld_eop_c;
          last_d  = ld_last_c;
          lo_d    = bus.in_value[15:0];
        end
      end
      HI: begin
        if (out_fire_c) begin
          state_d = LO;
          imm_d   = lo_q;
          eop_d   = EOP_ZEXT;
          last_d  = 1'b1;
        end
      end
      SINGLE, LO: begin
        // Final beat leaving; a waiting constant is loaded in the same cycle.
        if (out_fire_c) begin
          state_d = IDLE;
          if (in_fire_c) begin
            state_d = ld_state_c;
            imm_d   = ld_imm_c;
            eop_d   = ld_eop_c;
            last_d  = ld_last_c;
            lo_d    = bus.in_value[15:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (out_fire_c && last_q) begin
      value_cnt_d = value_cnt_q + CNT_W'(1);
    end
    if (out_fire_c && (state_q == LO)) begin
      split_cnt_d = split_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      imm_q       <= '0;
      eop_q       <= '0;
      last_q      <= 1'b0;
      lo_q        <= '0;
      value_cnt_q <= '0;
      split_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      imm_q       <= imm_d;
      eop_q       <= eop_d;
      last_q      <= last_d;
      lo_q        <= lo_d;
      value_cnt_q <= value_cnt_d;
      split_cnt_q <= split_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_imm   = imm_q;
  assign bus.out_eop   = eop_q;
  assign bus.out_last  = last_q;
  assign value_cnt     = value_cnt_q;
  assign split_cnt     = split_cnt_q;

endmodule
